// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive deserializer.
// State encoding, word-length codes, oversample sample points.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [1:0] NB5 = 2'b00;
  localparam logic [1:0] NB6 = 2'b01;
  localparam logic [1:0] NB7 = 2'b10;
  localparam logic [1:0] NB8 = 2'b11;

  localparam logic [3:0] MID_START = 4'd7;
  localparam logic [3:0] MID_BIT   = 4'd15;

  // Index of the last data bit (word length minus one).
  function automatic logic [2:0] last_idx(input logic [1:0] nb);
    logic [2:0] r;
    r = 3'd7;
    unique case (nb)
      NB5: r = 3'd4;
      NB6: r = 3'd5;
      NB7: r = 3'd6;
      NB8: r = 3'd7;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// Receive bus: baud enable, serial line, config and read strobe in;
// received word with status flags out. slave = receiver side.
interface uart_rx_deserializer_if;

  logic       brc;
  logic       sin;
  logic [1:0] num_bits;
  logic       parity_en;
  logic       parity_even;
  logic       rd;
  logic [7:0] dout;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       break_det;
  logic       overrun;

  modport master (
    output brc, sin, num_bits, parity_en, parity_even, rd,
    input  dout, valid, parity_err, frame_err, break_det, overrun
  );

  modport slave (
    input  brc, sin, num_bits, parity_en, parity_even, rd,
    output dout, valid, parity_err, frame_err, break_det, overrun
  );

endinterface

// File: rtl/uart_sipo_shift.sv
// 8-bit serial-in shift register, new bit enters at bit 7.
// Ports: clk, rst (async), clr (sync clear), en (shift), din, q.
module uart_sipo_shift (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (en)
      q <= {din, q[7:1]};
  end

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive bit engine: 16x oversampled start/data/parity/stop.
// Ports: clk, rst (async, active-high), bus (slave modport).
module uart_rx_deserializer
  import uart_rx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  uart_rx_deserializer_if.slave bus
);

  logic       s_meta, s, s_prev;
  state_t     state, state_nx;
  logic [3:0] cnt;
  logic [2:0] bitn, last_q;
  logic       pen_q, peven_q, pbit_q;
  logic       start_ok, cnt_clr, shift, psample, load;
  logic [7:0] shreg;
  logic [7:0] dout_q;
  logic       valid_q, perr_q, ferr_q, brk_q, ovr_q;
  logic       perr_nx, brk_nx;

  // s_prev is the line value seen at the previous brc, so only a
  // real high-to-low edge starts a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_meta <= 1'b1;
      s      <= 1'b1;
      s_prev <= 1'b1;
    end else begin
      s_meta <= bus.sin;
      s      <= s_meta;
      if (bus.brc)
        s_prev <= s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start_ok = 1'b0;
    cnt_clr  = 1'b0;
    shift    = 1'b0;
    psample  = 1'b0;
    load     = 1'b0;
    if (bus.brc) begin
      unique case (state)
        IDLE: begin
          if (!s && s_prev) begin
            state_nx = START;
            cnt_clr  = 1'b1;
          end
        end
        START: begin
          if (cnt == MID_START) begin
            cnt_clr = 1'b1;
            if (!s) begin
              state_nx = DATA;
              start_ok = 1'b1;
            end else begin
              state_nx = IDLE;
            end
          end
        end
        DATA: begin
          if (cnt == MID_BIT) begin
            shift = 1'b1;
            if (bitn == last_q)
              state_nx = pen_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (cnt == MID_BIT) begin
            psample  = 1'b1;
            state_nx = STOP;
          end
        end
        STOP: begin
          if (cnt == MID_BIT) begin
            load     = 1'b1;
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      bitn    <= '0;
      last_q  <= 3'd7;
      pen_q   <= 1'b0;
      peven_q <= 1'b0;
      pbit_q  <= 1'b0;
    end else begin
      if (bus.brc)
        cnt <= cnt_clr ? 4'd0 : cnt + 4'd1;
      if (start_ok) begin
        bitn    <= '0;
        last_q  <= last_idx(bus.num_bits);
        pen_q   <= bus.parity_en;
        peven_q <= bus.parity_even;
        pbit_q  <= 1'b0;
      end else begin
        if (shift)
          bitn <= bitn + 3'd1;
        if (psample)
          pbit_q <= s;
      end
    end
  end

  uart_sipo_shift u_shift (
    .clk (clk),
    .rst (rst),
    .clr (start_ok),
    .en  (shift),
    .din (s),
    .q   (shreg)
  );

  // Unused low bits of shreg stay zero, so whole-register XOR and
  // compare-to-zero cover exactly the received data bits.
  assign perr_nx = pen_q & (^shreg ^ pbit_q ^ ~peven_q);
  assign brk_nx  = (shreg == 8'd0) & ~(pen_q & pbit_q) & ~s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (load) begin
      dout_q  <= shreg >> (3'd7 - last_q);
      perr_q  <= perr_nx;
      ferr_q  <= ~s;
      brk_q   <= brk_nx;
      valid_q <= 1'b1;
      if (valid_q && !bus.rd)
        ovr_q <= 1'b1;
    end else if (bus.rd) begin
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.valid      = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.break_det  = brk_q;
  assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: frame-level reference model,
// per-cycle output compare, directed and randomized frames.
module tb_uart_rx_deserializer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_deserializer_if bus();

  uart_rx_deserializer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned at;
    logic [7:0]  d;
    logic        pe;
    logic        fe;
    logic        bk;
  } ev_t;

  ev_t q[$];
  int          rp = 0;
  int unsigned bcnt = 0;
  int unsigned rd_at = 0;
  logic        rd_man = 1'b0;
  logic        rnd_rd = 1'b0;
  int          phase = 0;

  logic [7:0] m_dout = '0;
  logic m_valid = 1'b0, m_pe = 1'b0, m_fe = 1'b0;
  logic m_bk = 1'b0, m_ov = 1'b0;

  int checks = 0, fails = 0;
  int lchecks = 0, lfails = 0;

  wire [12:0] outs = {bus.dout, bus.valid, bus.parity_err,
                      bus.frame_err, bus.break_det, bus.overrun};
  wire [12:0] mdl  = {m_dout, m_valid, m_pe, m_fe, m_bk, m_ov};

  // brc every 4 clk; rd from directed request, scheduled load
  // collision, or random strobes.
  initial begin
    bus.brc = 1'b0;
    bus.rd  = 1'b0;
    forever begin
      @(negedge clk);
      phase   = (phase + 1) % 4;
      bus.brc = (phase == 0);
      bus.rd  = rd_man
             || (bus.brc && rd_at != 0 && bcnt + 1 == rd_at)
             || (rnd_rd && $urandom_range(0, 39) == 0);
    end
  end

  // Reference: each frame's word becomes visible at its stop
  // mid-bit brc; rd clears valid/overrun unless a load coincides.
  always @(posedge clk) begin
    if (bus.brc)
      bcnt <= bcnt + 1;
    if (rst) begin
      m_dout  <= '0;
      m_valid <= 1'b0;
      m_pe    <= 1'b0;
      m_fe    <= 1'b0;
      m_bk    <= 1'b0;
      m_ov    <= 1'b0;
      rp      <= q.size();
    end else if (bus.brc && rp < q.size()
                 && q[rp].at == bcnt + 1) begin
      m_ov    <= m_ov | (m_valid & ~bus.rd);
      m_valid <= 1'b1;
      m_dout  <= q[rp].d;
      m_pe    <= q[rp].pe;
      m_fe    <= q[rp].fe;
      m_bk    <= q[rp].bk;
      rp      <= rp + 1;
    end else if (bus.rd) begin
      m_valid <= 1'b0;
      m_ov    <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks <= checks + 1;
      if (outs !== mdl) begin
        fails <= fails + 1;
        if (fails < 20)
          $display("FAIL cycle_cmp t=%0t dut=%h model=%h",
                   $time, outs, mdl);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic lcheck(input string nm, input logic [15:0] act,
                        input logic [15:0] exp);
    lchecks++;
    if (act !== exp) begin
      lfails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_brcs(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (bus.brc !== 1'b1) @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_rd();
    rd_man = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rd_man = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic expect_word(input int unsigned at,
                             input logic [7:0] d,
                             input logic pen, input logic peven,
                             input logic pbit, input logic stop);
    ev_t e;
    logic x;
    x    = (^d) ^ pbit;
    e.at = at;
    e.d  = d;
    e.pe = pen && (peven ? x : !x);
    e.fe = !stop;
    e.bk = (d == 8'd0) && !(pen && pbit) && !stop;
    q.push_back(e);
  endtask

  // Called right after a brc; start edge is seen on the next brc,
  // stop is sampled 8 + 16*(bits incl. start) brcs after that.
  task automatic send_frame(input logic [7:0] data,
                            input logic [1:0] nb,
                            input logic pen, input logic peven,
                            input logic badp, input logic stop,
                            input int idle, input logic rdl,
                            input logic scr);
    int n;
    logic [7:0] d;
    logic pbit;
    int unsigned at;
    n    = int'(nb) + 5;
    d    = data & (8'hFF >> (8 - n));
    pbit = (^d) ^ ~peven ^ badp;
    bus.num_bits    = nb;
    bus.parity_en   = pen;
    bus.parity_even = peven;
    at = bcnt + 1 + 8 + 16 * unsigned'(n + int'(pen) + 1);
    expect_word(at, d, pen, peven, pbit, stop);
    if (rdl)
      rd_at = at;
    bus.sin = 1'b0;
    wait_brcs(16);
    if (scr) begin
      bus.num_bits    = 2'($urandom);
      bus.parity_en   = 1'($urandom);
      bus.parity_even = 1'($urandom);
    end
    for (int k = 0; k < n; k++) begin
      bus.sin = d[k];
      wait_brcs(16);
    end
    if (pen) begin
      bus.sin = pbit;
      wait_brcs(16);
    end
    bus.sin = stop;
    wait_brcs(16);
    bus.sin = 1'b1;
    rd_at = 0;
    wait_brcs(idle);
  endtask

  initial begin
    bus.sin         = 1'b1;
    bus.num_bits    = 2'b11;
    bus.parity_en   = 1'b0;
    bus.parity_even = 1'b0;
    repeat (3) @(negedge clk);
    lcheck("reset_out", 16'(outs), 16'h0000);
    #1 rst = 1'b0;
    wait_brcs(4);
    lcheck("post_reset_out", 16'(outs), 16'h0000);

    // 8N1 0xA5
    send_frame(8'hA5, 2'b11, 0, 0, 0, 1, 2, 0, 0);
    lcheck("a5_out", 16'(outs), 16'({8'hA5, 5'b10000}));
    lcheck("a5_model", 16'(mdl), 16'({8'hA5, 5'b10000}));
    do_rd();
    lcheck("a5_rd", 16'(outs), 16'({8'hA5, 5'b00000}));
    wait_brcs(1);

    // 5E1 0x13, correct parity (1) then wrong parity (0)
    send_frame(8'h13, 2'b00, 1, 1, 0, 1, 2, 0, 0);
    lcheck("5e1_good", 16'(outs), 16'({8'h13, 5'b10000}));
    do_rd();
    wait_brcs(1);
    send_frame(8'h13, 2'b00, 1, 1, 1, 1, 2, 0, 0);
    lcheck("5e1_bad", 16'(outs), 16'({8'h13, 5'b11000}));
    lcheck("5e1_bad_model", 16'(mdl), 16'({8'h13, 5'b11000}));
    do_rd();
    wait_brcs(1);

    // 8N1 0x3C with stop low
    send_frame(8'h3C, 2'b11, 0, 0, 0, 0, 2, 0, 0);
    lcheck("frame_err", 16'(outs), 16'({8'h3C, 5'b10100}));
    do_rd();
    wait_brcs(1);

    // break: line low for 20 bit times
    bus.num_bits  = 2'b11;
    bus.parity_en = 1'b0;
    expect_word(bcnt + 1 + 8 + 16 * 9, 8'h00, 0, 0, 0, 0);
    bus.sin = 1'b0;
    wait_brcs(320);
    lcheck("break", 16'(outs), 16'({8'h00, 5'b10110}));
    lcheck("break_model", 16'(mdl), 16'({8'h00, 5'b10110}));
    do_rd();
    wait_brcs(40);
    lcheck("break_no_retrig", 16'(outs), 16'({8'h00, 5'b00110}));
    bus.sin = 1'b1;
    wait_brcs(4);
    send_frame(8'h81, 2'b11, 0, 0, 0, 1, 2, 0, 0);
    lcheck("after_break", 16'(outs), 16'({8'h81, 5'b10000}));
    do_rd();
    wait_brcs(1);

    // 4-brc glitch on idle line
    bus.sin = 1'b0;
    wait_brcs(4);
    bus.sin = 1'b1;
    wait_brcs(30);
    lcheck("glitch", 16'(outs), 16'({8'h81, 5'b00000}));

    // overrun, then rd colliding with a load
    send_frame(8'h11, 2'b11, 0, 0, 0, 1, 2, 0, 0);
    send_frame(8'h22, 2'b11, 0, 0, 0, 1, 2, 0, 0);
    lcheck("overrun", 16'(outs), 16'({8'h22, 5'b10001}));
    do_rd();
    lcheck("overrun_rd", 16'(outs), 16'({8'h22, 5'b00000}));
    wait_brcs(1);
    send_frame(8'h11, 2'b11, 0, 0, 0, 1, 0, 0, 0);
    send_frame(8'h22, 2'b11, 0, 0, 0, 1, 2, 1, 0);
    lcheck("rd_on_load", 16'(outs), 16'({8'h22, 5'b10000}));
    lcheck("rd_on_load_mdl", 16'(mdl), 16'({8'h22, 5'b10000}));

    // reset mid-DATA of 0xFF
    bus.sin = 1'b0;
    wait_brcs(16);
    bus.sin = 1'b1;
    wait_brcs(40);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    lcheck("mid_rst", 16'(outs), 16'h0000);
    #1 rst = 1'b0;
    wait_brcs(200);
    send_frame(8'h5A, 2'b11, 0, 0, 0, 1, 2, 0, 0);
    lcheck("after_rst", 16'(outs), 16'({8'h5A, 5'b10000}));
    do_rd();
    wait_brcs(1);

    // randomized frames, config scrambled mid-frame, random rd
    rnd_rd = 1'b1;
    for (int f = 0; f < 30; f++) begin
      logic stp;
      int   idl;
      stp = ($urandom_range(0, 7) != 0);
      idl = stp ? int'($urandom_range(0, 2))
                : int'($urandom_range(1, 3));
      send_frame(8'($urandom), 2'($urandom), 1'($urandom),
                 1'($urandom), ($urandom_range(0, 3) == 0),
                 stp, idl, 0, 1);
    end
    rnd_rd = 1'b0;
    wait_brcs(4);

    $display("%0d/%0d checks passed",
             (checks + lchecks) - (fails + lfails),
             checks + lchecks);
    $finish;
  end

endmodule
